row_accumulator: RTL

ROW_ACCUMULATOR -- requirements
Module: row_accumulator

---
 rtl/row_accumulator.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/row_accumulator.sv
// Per-lane row accumulator: pops a row length, then that many signed products, and emits the row sum.
// Optional ACC_SATURATE_EN clamps each add (sticky for the rest of the row) instead of wrapping.

module row_accumulator_lane #(
    parameter int val_bits = 16,
    parameter int acc_bits = 40,
    parameter int len_bits = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*val_bits-1:0] mult,
    input  logic                  mult_fifo_empty,
    output logic                  mult_fifo_read,
    input  logic [len_bits-1:0]   len,
    input  logic                  len_fifo_empty,
    output logic                  len_fifo_read,
    output logic [acc_bits-1:0]   sum,
    output logic                  sum_valid,
    input  logic                  sum_ready
);
    typedef enum logic [2:0] {IDLE, LEN, ACC, DRAIN, OUT} state_t;

    state_t              state, state_nxt;
    logic [len_bits-1:0] remaining;
    logic [acc_bits-1:0] acc, acc_add;
    logic                add_pend;
    logic [acc_bits-1:0] prod_ext;

    assign prod_ext = acc_bits'($signed(mult));

`ifdef ACC_SATURATE_EN
    localparam logic [acc_bits-1:0] ACC_MAX = {1'b0, {(acc_bits-1){1'b1}}};
    localparam logic [acc_bits-1:0] ACC_MIN = {1'b1, {(acc_bits-1){1'b0}}};
    logic [acc_bits:0] acc_wide;
    logic              ovf, sat_hold;

    assign acc_wide = {acc[acc_bits-1], acc} + {prod_ext[acc_bits-1], prod_ext};
    assign ovf      = acc_wide[acc_bits] != acc_wide[acc_bits-1];

    // Once clamped, the accumulator ignores further products until the next row.
    always_comb begin
        acc_add = acc_wide[acc_bits-1:0];
        if (sat_hold)
            acc_add = acc;
        else if (ovf)
            acc_add = acc_wide[acc_bits] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_hold <= 1'b0;
        else if (state == LEN)
            sat_hold <= 1'b0;
        else if (add_pend && ovf)
            sat_hold <= 1'b1;
    end
`else
    assign acc_add = acc + prod_ext;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            add_pend  <= 1'b0;
        end else begin
            state    <= state_nxt;
            add_pend <= mult_fifo_read;
            if (state == LEN) begin
                remaining <= len;
                acc       <= '0;
            end else begin
                if (mult_fifo_read)
                    remaining <= remaining - len_bits'(1);
                // FIFO data arrives one cycle after the pop, hence the pending-add register.
                if (add_pend)
                    acc <= acc_add;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        mult_fifo_read = 1'b0;
        len_fifo_read  = 1'b0;
        sum_valid      = 1'b0;
        case (state)
            IDLE: begin
                len_fifo_read = ~len_fifo_empty;
                if (!len_fifo_empty)
                    state_nxt = LEN;
            end
            LEN:   state_nxt = (len == '0) ? OUT : ACC;
            ACC: begin
                mult_fifo_read = ~mult_fifo_empty;
                if (!mult_fifo_empty && remaining == len_bits'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = OUT;
            OUT: begin
                sum_valid = 1'b1;
                if (sum_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sum = sum_valid ? acc : '0;
endmodule

module row_accumulator #(
    parameter int channel_num = 4,
    parameter int val_bits    = 16,
    parameter int acc_bits    = 40,  // must be >= 2*val_bits
    parameter int len_bits    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [channel_num*2*val_bits-1:0] mult,
    input  logic [channel_num-1:0]            mult_fifo_empty,
    output logic [channel_num-1:0]            mult_fifo_read,
    input  logic [channel_num*len_bits-1:0]   len,
    input  logic [channel_num-1:0]            len_fifo_empty,
    output logic [channel_num-1:0]            len_fifo_read,
    output logic [channel_num*acc_bits-1:0]   sum,
    output logic [channel_num-1:0]            sum_valid,
    input  logic [channel_num-1:0]            sum_ready
);
    for (genvar i = 0; i < channel_num; i++) begin : g_lane
        row_accumulator_lane #(
            .val_bits(val_bits),
            .acc_bits(acc_bits),
            .len_bits(len_bits)
        ) u_lane (
            .clk             (clk),
            .rst             (rst),
            .mult            (mult[i*2*val_bits +: 2*val_bits]),
            .mult_fifo_empty (mult_fifo_empty[i]),
            .mult_fifo_read  (mult_fifo_read[i]),
            .len             (len[i*len_bits +: len_bits]),
            .len_fifo_empty  (len_fifo_empty[i]),
            .len_fifo_read   (len_fifo_read[i]),
            .sum             (sum[i*acc_bits +: acc_bits]),
            .sum_valid       (sum_valid[i]),
            .sum_ready       (sum_ready[i])
        );
    end
endmodule
